layer_compositor: RTL and testbench
===================================

Name: layer_compositor

Overview:
- Parametrised successor to the fixed priority mux that feeds Screens_dispaly: composites N_LAYERS object layers plus background and a full-screen overlay into one registered 4/4/4 RGB pixel.
- Detects overlap between a designated "player" layer and every other collidable layer.
- Collisions are accumulated per frame and reported once per frame as single-cycle pulses, instead of being driven combinationally on every overlapping pixel.
- Sits between the object draw units (bird, buildings, lightning, etc.) and Screens_dispaly, on clk_25.

Parameters:
- N_LAYERS, 8, number of object layers (2..16); index 0 = highest draw priority.
- PLAYER_IDX, 0, layer index checked against all others for collision.
- COLL_MASK, {N_LAYERS{1'b1}}, bit k=1 means layer k is collidable with the player; bit PLAYER_IDX is ignored.
- TRANSPARENT_RGB, 12'hF0F, colour key, used only when the optional feature is compiled in.

Ports:
- clk  in  1  pixel clock (clk_25).
- resetN  in  1  asynchronous active-low reset.
- pxl_x  in  32  current pixel column.
- pxl_y  in  32  current pixel row.
- layer_draw  in  N_LAYERS  per-layer drawing request for the current pixel.
- layer_rgb  in  12*N_LAYERS  per-layer colour; layer k occupies bits [12k+11:12k] as {R[3:0],G[3:0],B[3:0]}.
- background_rgb  in  12  background colour.
- overlay_en  in  1  full-screen overlay enable (game over).
- overlay_rgb  in  12  overlay colour.
- Red_level  out  4  composited red.
- Green_level  out  4  composited green.
- Blue_level  out  4  composited blue.
- frame_start  out  1  one-cycle pulse at the first pixel of each frame.
- collision  out  N_LAYERS  per-layer one-cycle collision pulse, asserted together with frame_start.
- collision_any  out  1  OR of collision.

Behaviour:
- Clocking and reset:
  - One clock; asynchronous active-low reset.
  - All outputs and internal state reset to 0, so RGB outputs are black.
- Colour selection (result registered, latency exactly 1 cycle from inputs to RGB outputs):
  - If overlay_en = 1: output overlay_rgb.
  - Else if any layer is drawing: output the colour of the lowest-index drawing layer.
  - Else: output background_rgb.
- Effective draw: eff_draw[k] = layer_draw[k], except when the optional feature masks it (see below).
- Frame detection:
  - at_origin = (pxl_x==0 && pxl_y==0), registered as at_origin_d.
  - frame_start pulses in the cycle after at_origin rises (rising-edge detect), so a held origin during blanking yields a single pulse.
- Collision accumulation:
  - hit[k] is sticky within a frame.
  - Per-pixel condition: eff_draw[PLAYER_IDX] && eff_draw[k] && COLL_MASK[k], for k != PLAYER_IDX.
  - The condition is evaluated on the same registered inputs used for colour.
  - overlay_en does not suppress collision detection.
- Frame boundary (cycle where frame_start = 1):
  - collision <= hit & {N_LAYERS{frame_valid}}.
  - hit is reloaded with only the current pixel's condition, which belongs to the new frame.
  - frame_valid <= 1.
  - In all other cycles collision = 0.
- frame_valid:
  - Cleared by reset.
  - Suppresses the report for the partial frame that follows reset, so the first collision pulse can occur only at the second frame_start after reset.
- collision_any is registered alongside collision and equals its OR.
- collision[PLAYER_IDX] is always 0.
- Boundary cases:
  - Reset mid-frame clears hit and frame_valid immediately.
  - Coordinates jumping to origin without passing the last pixel still count as a frame start.
  - N_LAYERS=2 with PLAYER_IDX=1 is legal.
- Width rules: pxl_x and pxl_y are compared at full 32 bits; no truncation.

Optional Feature:
- Macro: LAYER_COMPOSITOR_TRANSPARENT_KEY_EN.
- Defined:
  - eff_draw[k] = layer_draw[k] && (layer_rgb[k] != TRANSPARENT_RGB).
  - Keyed pixels fall through to lower-priority layers or background.
  - Keyed pixels neither draw nor collide.
- Undefined: eff_draw = layer_draw; no comparators are synthesised and TRANSPARENT_RGB is unused.

Test Plan:
- Reset and latency:
  - Stimulus: assert resetN=0 mid-stream, then release; set layer 2 draw with rgb 12'h0A5 and nothing else.
  - Required: RGB = 0,0,0 during reset; R=0, G=A, B=5 exactly one clk after the input is applied.
- Priority:
  - Stimulus: layers 1 (12'hF00) and 3 (12'h00F) both draw.
  - Required: output F,0,0.
  - Stimulus: then overlay_en=1 with 12'h777.
  - Required: output 7,7,7.
  - Stimulus: no layers drawing, background 12'h123.
  - Required: output 1,2,3.
- Collision per frame:
  - Stimulus: player (layer 0) overlaps layer 4 on 50 pixels of frame 2.
  - Required: at the next origin, one frame_start pulse with collision=8'h10 and collision_any=1; all other cycles collision=0; at the following frame with no overlap, collision=0.
- Masking and first frame:
  - Stimulus: COLL_MASK=8'hEF with overlap on layer 4.
  - Required: collision stays 0.
  - Stimulus: overlap occurs in the partial frame after reset.
  - Required: no pulse at the first frame_start.
- Origin held and origin-pixel hit:
  - Stimulus: hold pxl_x=pxl_y=0 for 100 cycles.
  - Required: exactly one frame_start pulse.
  - Stimulus: overlap on the (0,0) pixel itself.
  - Required: reported at the next frame, not the current one.
- Transparency (macro defined):
  - Stimulus: layer 0 drawing 12'hF0F over layer 1 drawing 12'h0F0.
  - Required: output 0,F,0 and no collision reported for layer 1.
  - Stimulus: same with the macro undefined.
  - Required: output F,0,F and collision[1] reported.

Source files
------------

// File: rtl/layer_compositor.sv
// Composites N_LAYERS object layers plus background/overlay into one 4/4/4 pixel; reports per-frame player collisions.
// Latency: 1 cycle from inputs to RGB, frame_start and collision outputs. Backpressure: none, one pixel per clock.
// Optional colour-key transparency is compiled in with LAYER_COMPOSITOR_TRANSPARENT_KEY_EN.
module layer_compositor #(
    parameter int                   N_LAYERS        = 8,
    parameter int                   PLAYER_IDX      = 0,
    parameter logic [N_LAYERS-1:0]  COLL_MASK       = {N_LAYERS{1'b1}},
    parameter logic [11:0]          TRANSPARENT_RGB = 12'hF0F
) (
    input  logic                    clk,
    input  logic                    resetN,
    input  logic [31:0]             pxl_x,
    input  logic [31:0]             pxl_y,
    input  logic [N_LAYERS-1:0]     layer_draw,
    input  logic [12*N_LAYERS-1:0]  layer_rgb,
    input  logic [11:0]             background_rgb,
    input  logic                    overlay_en,
    input  logic [11:0]             overlay_rgb,
    output logic [3:0]              Red_level,
    output logic [3:0]              Green_level,
    output logic [3:0]              Blue_level,
    output logic                    frame_start,
    output logic [N_LAYERS-1:0]     collision,
    output logic                    collision_any
);

    localparam logic [N_LAYERS-1:0] ONE_HOT_LSB = {{(N_LAYERS-1){1'b0}}, 1'b1};
    // The player never collides with itself, whatever COLL_MASK says.
    localparam logic [N_LAYERS-1:0] ACTIVE_MASK = COLL_MASK & ~(ONE_HOT_LSB << PLAYER_IDX);

    logic [N_LAYERS-1:0] eff_draw;
    logic [11:0]         pix_rgb;
    logic [N_LAYERS-1:0] pix_hit;
    logic                at_origin;
    logic                frame_edge;

    logic [11:0]         rgb_q;
    logic                at_origin_d;
    logic                frame_start_q;
    logic [N_LAYERS-1:0] hit;
    logic                frame_valid;
    logic [N_LAYERS-1:0] collision_q;
    logic                collision_any_q;

`ifdef LAYER_COMPOSITOR_TRANSPARENT_KEY_EN
    // Keyed pixels neither draw nor collide, so they fall through to lower layers.
    for (genvar k = 0; k < N_LAYERS; k++) begin : g_key
        assign eff_draw[k] = layer_draw[k] && (layer_rgb[12*k +: 12] != TRANSPARENT_RGB);
    end
`else
    assign eff_draw = layer_draw;
    if (TRANSPARENT_RGB == 12'h000) begin : g_key_unused
    end
`endif

    always_comb begin
        pix_rgb = background_rgb;
        for (int k = N_LAYERS - 1; k >= 0; k--) begin
            if (eff_draw[k]) begin
                pix_rgb = layer_rgb[12*k +: 12];
            end
        end
        if (overlay_en) begin
            pix_rgb = overlay_rgb;
        end
    end

    assign pix_hit    = {N_LAYERS{eff_draw[PLAYER_IDX]}} & eff_draw & ACTIVE_MASK;
    assign at_origin  = (pxl_x == 32'd0) && (pxl_y == 32'd0);
    // Rising edge only: an origin held through blanking starts a single frame.
    assign frame_edge = at_origin && !at_origin_d;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            rgb_q           <= 12'h000;
            at_origin_d     <= 1'b0;
            frame_start_q   <= 1'b0;
            hit             <= '0;
            frame_valid     <= 1'b0;
            collision_q     <= '0;
            collision_any_q <= 1'b0;
        end else begin
            rgb_q         <= pix_rgb;
            at_origin_d   <= at_origin;
            frame_start_q <= frame_edge;
            if (frame_edge) begin
                // The origin pixel's own overlap belongs to the frame that starts here.
                collision_q     <= hit & {N_LAYERS{frame_valid}};
                collision_any_q <= (|hit) && frame_valid;
                hit             <= pix_hit;
                frame_valid     <= 1'b1;
            end else begin
                collision_q     <= '0;
                collision_any_q <= 1'b0;
                hit             <= hit | pix_hit;
            end
        end
    end

    assign Red_level     = rgb_q[11:8];
    assign Green_level   = rgb_q[7:4];
    assign Blue_level    = rgb_q[3:0];
    assign frame_start   = frame_start_q;
    assign collision     = collision_q;
    assign collision_any = collision_any_q;

endmodule

// File: tb/tb_layer_compositor.sv
// Randomised and directed bench for layer_compositor with a frame-level reference model.
module tb_layer_compositor;

    localparam int N = 8;
    localparam int W = 20;
    localparam int H = 5;
    localparam logic [7:0] MASK_A = 8'hFF;
    localparam logic [7:0] MASK_B = 8'hEF;

    logic          clk = 1'b0;
    logic          resetN;
    logic [31:0]   pxl_x, pxl_y;
    logic [N-1:0]  layer_draw;
    logic [12*N-1:0] layer_rgb;
    logic [11:0]   background_rgb;
    logic          overlay_en;
    logic [11:0]   overlay_rgb;

    logic [3:0]    r_a, g_a, b_a, r_b, g_b, b_b;
    logic          fs_a, fs_b, any_a, any_b;
    logic [N-1:0]  coll_a, coll_b;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    layer_compositor #(.N_LAYERS(N), .PLAYER_IDX(0), .COLL_MASK(MASK_A)) dut (
        .clk(clk), .resetN(resetN), .pxl_x(pxl_x), .pxl_y(pxl_y),
        .layer_draw(layer_draw), .layer_rgb(layer_rgb), .background_rgb(background_rgb),
        .overlay_en(overlay_en), .overlay_rgb(overlay_rgb),
        .Red_level(r_a), .Green_level(g_a), .Blue_level(b_a),
        .frame_start(fs_a), .collision(coll_a), .collision_any(any_a));

    layer_compositor #(.N_LAYERS(N), .PLAYER_IDX(0), .COLL_MASK(MASK_B)) dut_m (
        .clk(clk), .resetN(resetN), .pxl_x(pxl_x), .pxl_y(pxl_y),
        .layer_draw(layer_draw), .layer_rgb(layer_rgb), .background_rgb(background_rgb),
        .overlay_en(overlay_en), .overlay_rgb(overlay_rgb),
        .Red_level(r_b), .Green_level(g_b), .Blue_level(b_b),
        .frame_start(fs_b), .collision(coll_b), .collision_any(any_b));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: which layers are visible, which colour wins, and how many
    // overlap pixels each layer had with the player in the current frame.
    logic [11:0] exp_rgb;
    logic        exp_fs;
    logic [7:0]  exp_coll_a, exp_coll_b;
    bit          prev_origin;
    int          frames_seen;
    int          overlap_cnt [N];

    function automatic logic [7:0] visible();
        logic [7:0] v;
        for (int k = 0; k < N; k++) begin
`ifdef LAYER_COMPOSITOR_TRANSPARENT_KEY_EN
            v[k] = layer_draw[k] && (layer_rgb[12*k +: 12] != 12'hF0F);
`else
            v[k] = layer_draw[k];
`endif
        end
        return v;
    endfunction

    function automatic logic [11:0] winner(input logic [7:0] v);
        if (overlay_en) return overlay_rgb;
        for (int k = 0; k < N; k++)
            if (v[k]) return layer_rgb[12*k +: 12];
        return background_rgb;
    endfunction

    always @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            exp_rgb = 12'h000; exp_fs = 1'b0; exp_coll_a = 8'h00; exp_coll_b = 8'h00;
            prev_origin = 1'b0; frames_seen = 0;
            for (int k = 0; k < N; k++) overlap_cnt[k] = 0;
        end else begin
            logic [7:0] v;
            bit origin, starting;
            v = visible();
            origin = (pxl_x == 0) && (pxl_y == 0);
            starting = origin && !prev_origin;
            prev_origin = origin;
            exp_rgb = winner(v);
            exp_fs = starting;
            exp_coll_a = 8'h00;
            exp_coll_b = 8'h00;
            if (starting) begin
                if (frames_seen > 0) begin
                    for (int k = 1; k < N; k++) begin
                        exp_coll_a[k] = (overlap_cnt[k] > 0) && MASK_A[k];
                        exp_coll_b[k] = (overlap_cnt[k] > 0) && MASK_B[k];
                    end
                end
                frames_seen++;
                for (int k = 0; k < N; k++) overlap_cnt[k] = 0;
            end
            if (v[0])
                for (int k = 1; k < N; k++)
                    if (v[k]) overlap_cnt[k]++;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("rgb_a", {20'h0, r_a, g_a, b_a}, {20'h0, exp_rgb});
            chk("frame_start_a", {31'h0, fs_a}, {31'h0, exp_fs});
            chk("collision_a", {23'h0, any_a, coll_a}, {23'h0, |exp_coll_a, exp_coll_a});
            chk("rgb_b", {20'h0, r_b, g_b, b_b}, {20'h0, exp_rgb});
            chk("frame_start_b", {31'h0, fs_b}, {31'h0, exp_fs});
            chk("collision_b", {23'h0, any_b, coll_b}, {23'h0, |exp_coll_b, exp_coll_b});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pixel(input logic [31:0] x, input logic [31:0] y, input logic [7:0] d);
        pxl_x = x; pxl_y = y; layer_draw = d;
        tick();
    endtask

    task automatic rand_colours();
        for (int k = 0; k < N; k++)
            layer_rgb[12*k +: 12] = ($urandom_range(0, 5) == 0) ? 12'hF0F : 12'($urandom);
        background_rgb = 12'($urandom);
        overlay_rgb    = 12'($urandom);
        overlay_en     = ($urandom_range(0, 7) == 0);
    endtask

    task automatic run_frame(input int ovl, input int n, input bit rnd,
                             output logic fs, output logic [7:0] c, output logic ca,
                             output logic [7:0] cm);
        int idx;
        bit quit;
        idx = 0; quit = 1'b0; fs = 1'b0; c = 8'h00; ca = 1'b0; cm = 8'h00;
        for (int y = 0; y < H && !quit; y++) begin
            for (int x = 0; x < W && !quit; x++) begin
                logic [7:0] d;
                if (rnd) begin
                    rand_colours();
                    d = 8'($urandom) & 8'($urandom);
                    if (idx > 0 && $urandom_range(0, 29) == 0) pixel(32'h0, 32'h8000_0000, d);
                    if (idx > 0 && $urandom_range(0, 29) == 0) pixel(32'h0001_0000, 32'h0, d);
                end else begin
                    d = (ovl >= 0 && idx < n) ? (8'h01 | (8'h01 << ovl)) : 8'h00;
                end
                pixel(x, y, d);
                if (idx == 0) begin
                    fs = fs_a; c = coll_a; ca = any_a; cm = coll_b;
                end
                idx++;
                if (rnd && idx > 10 && $urandom_range(0, 99) == 0) quit = 1'b1;
            end
        end
    endtask

    initial begin
        logic fs, ca;
        logic [7:0] c, cm;
        int pulses;
        logic [7:0] first_coll;

        resetN = 1'b0; pxl_x = 0; pxl_y = 0; layer_draw = '0; layer_rgb = '0;
        background_rgb = 12'h000; overlay_en = 1'b0; overlay_rgb = 12'h000;
        tick(); tick(); tick();
        chk_en = 1'b1;
        tick();
        chk("reset_rgb", {20'h0, r_a, g_a, b_a}, 32'h000);
        chk("reset_coll", {23'h0, any_a, coll_a}, 32'h0);

        // Latency: layer 2 alone, one clock after release
        pxl_x = 5; pxl_y = 5;
        layer_rgb[12*2 +: 12] = 12'h0A5;
        layer_draw = 8'h04;
        resetN = 1'b1;
        tick();
        chk("latency_rgb", {20'h0, r_a, g_a, b_a}, 32'h0A5);

        layer_rgb[12*1 +: 12] = 12'hF00;
        layer_rgb[12*3 +: 12] = 12'h00F;
        layer_draw = 8'h0A;
        tick();
        chk("priority_rgb", {20'h0, r_a, g_a, b_a}, 32'hF00);
        overlay_en = 1'b1; overlay_rgb = 12'h777;
        tick();
        chk("overlay_rgb", {20'h0, r_a, g_a, b_a}, 32'h777);
        overlay_en = 1'b0; layer_draw = 8'h00; background_rgb = 12'h123;
        tick();
        chk("background_rgb", {20'h0, r_a, g_a, b_a}, 32'h123);

        // Overlap in the partial frame after reset must not be reported
        layer_rgb[12*0 +: 12] = 12'h800;
        layer_rgb[12*4 +: 12] = 12'h0C0;
        pixel(6, 5, 8'h11); pixel(7, 5, 8'h11); pixel(8, 5, 8'h11);
        run_frame(4, 50, 1'b0, fs, c, ca, cm);
        chk("first_frame_start", {31'h0, fs}, 32'h1);
        chk("first_frame_coll", {23'h0, ca, c}, 32'h0);

        run_frame(-1, 0, 1'b0, fs, c, ca, cm);
        chk("frame2_start", {31'h0, fs}, 32'h1);
        chk("frame2_coll", {23'h0, ca, c}, 32'h110);
        chk("frame2_coll_masked", {24'h0, cm}, 32'h0);

        // Origin held 100 cycles, with an overlap on the origin pixel itself
        pulses = 0; first_coll = 8'hFF;
        for (int i = 0; i < 100; i++) begin
            pixel(0, 0, (i == 0) ? 8'h09 : 8'h00);
            if (fs_a) pulses++;
            if (i == 0) first_coll = coll_a;
        end
        chk("held_origin_pulses", pulses, 1);
        chk("no_overlap_frame_coll", {24'h0, first_coll}, 32'h0);

        layer_rgb[12*0 +: 12] = 12'hF0F;
        layer_rgb[12*1 +: 12] = 12'h0F0;
        for (int idx = 1; idx < W * H; idx++) begin
            if (idx == 3 * W + 3) begin
                pixel(3, 3, 8'h03);
`ifdef LAYER_COMPOSITOR_TRANSPARENT_KEY_EN
                chk("keyed_rgb", {20'h0, r_a, g_a, b_a}, 32'h0F0);
`else
                chk("keyed_rgb", {20'h0, r_a, g_a, b_a}, 32'hF0F);
`endif
            end else begin
                pixel(idx % W, idx / W, 8'h00);
            end
        end
        run_frame(-1, 0, 1'b0, fs, c, ca, cm);
`ifdef LAYER_COMPOSITOR_TRANSPARENT_KEY_EN
        chk("origin_hit_coll", {23'h0, ca, c}, 32'h108);
        chk("origin_hit_coll_masked", {24'h0, cm}, 32'h08);
`else
        chk("origin_hit_coll", {23'h0, ca, c}, 32'h10A);
        chk("origin_hit_coll_masked", {24'h0, cm}, 32'h0A);
`endif

        // Reset mid-frame drops the accumulated overlap and the valid flag
        layer_rgb[12*0 +: 12] = 12'h800;
        layer_rgb[12*5 +: 12] = 12'h00C;
        pixel(7, 2, 8'h21); pixel(8, 2, 8'h21); pixel(9, 2, 8'h21);
        resetN = 1'b0;
        tick();
        chk("midreset_rgb", {20'h0, r_a, g_a, b_a}, 32'h0);
        chk("midreset_fs", {31'h0, fs_a}, 32'h0);
        resetN = 1'b1;
        run_frame(-1, 0, 1'b0, fs, c, ca, cm);
        chk("after_reset_coll", {23'h0, ca, c}, 32'h0);
        run_frame(-1, 0, 1'b0, fs, c, ca, cm);
        chk("after_reset_coll2", {23'h0, ca, c}, 32'h0);

        for (int f = 0; f < 30; f++) begin
            run_frame(-1, 0, 1'b1, fs, c, ca, cm);
            if (f == 14) begin
                rand_colours();
                pixel(4, 1, 8'($urandom));
                pixel(5, 1, 8'($urandom));
                resetN = 1'b0;
                tick(); tick();
                resetN = 1'b1;
            end
        end

        tick(); tick();
        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
